// File: rtl/lockstep_dmem_ctrl_if.sv
// Data-port bundle between the two lockstep cores, the controller and sp_ram.
// master: the controller's view. slave: the cores plus memory, i.e. the environment.
interface lockstep_dmem_ctrl_if;
  logic        a_req_i,   b_req_i;
  logic        a_we_i,    b_we_i;
  logic [3:0]  a_be_i,    b_be_i;
  logic [31:0] a_addr_i,  b_addr_i;
  logic [31:0] a_wdata_i, b_wdata_i;
  logic        a_gnt_o,   b_gnt_o;
  logic        a_rvalid_o, b_rvalid_o;
  logic [31:0] rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport master (
    input  a_req_i, b_req_i, a_we_i, b_we_i, a_be_i, b_be_i,
           a_addr_i, b_addr_i, a_wdata_i, b_wdata_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, rdata_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    output a_req_i, b_req_i, a_we_i, b_we_i, a_be_i, b_be_i,
           a_addr_i, b_addr_i, a_wdata_i, b_wdata_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, rdata_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/lockstep_dmem_ctrl.sv
// Lockstep data-memory controller: pairs the requests of two cores, compares
// them, issues a single memory access on a match and broadcasts the response.
// Divergence or a missing peer request is latched as a fault; memory is never
// touched with divergent data.
module lockstep_dmem_ctrl #(
  parameter int SKEW_MAX = 4,  // 1..15
  parameter int CNT_W    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  lockstep_dmem_ctrl_if.master bus,
  input  logic                 clear_i,
  output logic                 fault_o,
  output logic [1:0]           fault_cause_o,
  output logic [CNT_W-1:0]     fault_cnt_o
);

  typedef enum logic [2:0] {IDLE, WAIT_PEER, ISSUE, WAIT_RSP, FAULT} state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_MISM = 2'b01;
  localparam logic [1:0] CAUSE_TOUT = 2'b10;
  localparam logic [3:0] SKEW_LIM   = 4'(SKEW_MAX);

  // wdata only matters for writes; reads with junk on the data bus still match
  function automatic logic req_match(dreq_t x, dreq_t y);
    return (x.we == y.we) && (x.be == y.be) && (x.addr == y.addr) &&
           (!x.we || (x.wdata == y.wdata));
  endfunction

  state_e           state_q, state_d;
  dreq_t            cap_q, cap_d;
  logic             first_q, first_d;  // 0: A arrived first, 1: B arrived first
  logic [3:0]       timer_q, timer_d;
  logic [3:0]       timer_inc;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q;
  logic             enter_fault;
  dreq_t            req_a, req_b, peer;
  logic             peer_req;
  logic             in_issue, in_rsp;

  assign req_a     = '{we: bus.a_we_i, be: bus.a_be_i, addr: bus.a_addr_i, wdata: bus.a_wdata_i};
  assign req_b     = '{we: bus.b_we_i, be: bus.b_be_i, addr: bus.b_addr_i, wdata: bus.b_wdata_i};
  assign peer      = first_q ? req_a : req_b;
  assign peer_req  = first_q ? bus.a_req_i : bus.b_req_i;
  assign timer_inc = timer_q + 4'd1;

  // state, capture register, skew timer and latched fault cause
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cap_q   <= '0;
      first_q <= 1'b0;
      timer_q <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      first_q <= first_d;
      timer_q <= timer_d;
      cause_q <= cause_d;
    end
  end

  // next-state: pairing, compare, issue, response and fault handling
  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    first_d     = first_q;
    timer_d     = timer_q;
    cause_d     = cause_q;
    enter_fault = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.a_req_i && bus.b_req_i) begin
          if (req_match(req_a, req_b)) begin
            cap_d   = req_a;
            state_d = ISSUE;
          end else begin
            cause_d     = CAUSE_MISM;
            enter_fault = 1'b1;
            state_d     = FAULT;
          end
        end else if (bus.a_req_i || bus.b_req_i) begin
          cap_d   = bus.a_req_i ? req_a : req_b;
          first_d = bus.b_req_i;
          timer_d = '0;
          state_d = WAIT_PEER;
        end
      end
      WAIT_PEER: begin
        // timer_inc is the number of cycles since the first request; a peer
        // showing up on the SKEW_MAX-th cycle is already too late
        if (timer_inc == SKEW_LIM) begin
          cause_d     = CAUSE_TOUT;
          enter_fault = 1'b1;
          state_d     = FAULT;
        end else if (peer_req) begin
          if (req_match(cap_q, peer)) begin
            state_d = ISSUE;
          end else begin
            cause_d     = CAUSE_MISM;
            enter_fault = 1'b1;
            state_d     = FAULT;
          end
        end else begin
          timer_d = timer_inc;
        end
      end
      ISSUE:    if (bus.mem_gnt_i)    state_d = WAIT_RSP;
      WAIT_RSP: if (bus.mem_rvalid_i) state_d = IDLE;
      FAULT: begin
        if (clear_i) begin
          cause_d = CAUSE_NONE;
          cap_d   = '0;
          first_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // saturating fault counter, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      cnt_q <= '0;
    else if (enter_fault && ~&cnt_q)  cnt_q <= cnt_q + CNT_W'(1);
  end

  assign in_issue = (state_q == ISSUE);
  assign in_rsp   = (state_q == WAIT_RSP);

  // memory side: captured fields, gated so nothing leaks outside ISSUE
  assign bus.mem_req_o   = in_issue;
  assign bus.mem_we_o    = in_issue & cap_q.we;
  assign bus.mem_be_o    = in_issue ? cap_q.be    : '0;
  assign bus.mem_addr_o  = in_issue ? cap_q.addr  : '0;
  assign bus.mem_wdata_o = in_issue ? cap_q.wdata : '0;

  // core side: grant/response pass-through, broadcast to both cores
  assign bus.a_gnt_o    = in_issue & bus.mem_gnt_i;
  assign bus.b_gnt_o    = in_issue & bus.mem_gnt_i;
  assign bus.a_rvalid_o = in_rsp & bus.mem_rvalid_i;
  assign bus.b_rvalid_o = in_rsp & bus.mem_rvalid_i;
  assign bus.rdata_o    = (in_rsp && bus.mem_rvalid_i) ? bus.mem_rdata_i : '0;

  assign fault_o       = (state_q == FAULT);
  assign fault_cause_o = cause_q;
  assign fault_cnt_o   = cnt_q;

endmodule

// File: tb/tb_lockstep_dmem_ctrl.sv
// Directed bench for lockstep_dmem_ctrl. Inputs change 1 ns after the rising
// edge, outputs are sampled 4 ns after it; "cycle 0" is the cycle the first
// request is presented.
module tb_lockstep_dmem_ctrl;
  localparam int SKEW_MAX = 4;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear;
  logic             fault;
  logic [1:0]       fault_cause;
  logic [CNT_W-1:0] fault_cnt;
  int               n_cmp = 0;
  int               n_err = 0;
  int               req_cycles = 0;
  int               base;

  lockstep_dmem_ctrl_if bus();

  lockstep_dmem_ctrl #(.SKEW_MAX(SKEW_MAX), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .bus          (bus.master),
    .clear_i      (clear),
    .fault_o      (fault),
    .fault_cause_o(fault_cause),
    .fault_cnt_o  (fault_cnt)
  );

  always #5 clk = ~clk;

  // number of cycles a memory request was presented
  always @(negedge clk) if (bus.mem_req_o) req_cycles <= req_cycles + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.a_req_i = req; bus.a_we_i = we; bus.a_be_i = be;
    bus.a_addr_i = addr; bus.a_wdata_i = wdata;
  endtask

  task automatic drv_b(input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.b_req_i = req; bus.b_we_i = we; bus.b_be_i = be;
    bus.b_addr_i = addr; bus.b_wdata_i = wdata;
  endtask

  task automatic idle_cores();
    drv_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drv_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // one mismatching write pair, then acknowledge: three cycles per fault
  task automatic fault_once();
    cyc();
    drv_a(1'b1, 1'b1, 4'hF, 32'h900, 32'h1);
    drv_b(1'b1, 1'b1, 4'hF, 32'h900, 32'h2);
    cyc();
    idle_cores(); clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    idle_cores();
    clear = 1'b0;
    bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;

    // reset state
    #3;
    chk("rst_mem_req", 32'(bus.mem_req_o), 32'h0);
    chk("rst_fault", {29'h0, fault, fault_cause}, 32'h0);
    chk("rst_cnt", 32'(fault_cnt), 32'h0);
    #9 rst_n = 1'b1;

    // 1: aligned write, zero-wait memory
    cyc();
    drv_a(1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF);
    drv_b(1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF);
    base = req_cycles;
    #3 chk("t1_c0_req", 32'(bus.mem_req_o), 32'h0);
    cyc();
    #3;
    chk("t1_c1_req", 32'(bus.mem_req_o), 32'h1);
    chk("t1_c1_we", 32'(bus.mem_we_o), 32'h1);
    chk("t1_c1_be", 32'(bus.mem_be_o), 32'hF);
    chk("t1_c1_addr", bus.mem_addr_o, 32'h100);
    chk("t1_c1_wdata", bus.mem_wdata_o, 32'hDEADBEEF);
    chk("t1_c1_gnt", {30'h0, bus.a_gnt_o, bus.b_gnt_o}, 32'h3);
    cyc();
    idle_cores(); bus.mem_rvalid_i = 1'b1;
    #3;
    chk("t1_c2_rvalid", {30'h0, bus.a_rvalid_o, bus.b_rvalid_o}, 32'h3);
    chk("t1_c2_req", 32'(bus.mem_req_o), 32'h0);
    cyc();
    #3;
    chk("t1_c3_rvalid_gated", {30'h0, bus.a_rvalid_o, bus.b_rvalid_o}, 32'h0);
    chk("t1_one_issue", 32'(req_cycles - base), 32'h1);
    chk("t1_no_fault", 32'(fault), 32'h0);
    bus.mem_rvalid_i = 1'b0;

    // 2: skewed read, B three cycles behind A
    cyc();
    drv_a(1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      if (i == 3) drv_b(1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
      #3 chk($sformatf("t2_c%0d_req", i), 32'(bus.mem_req_o), 32'h0);
    end
    cyc();
    #3;
    chk("t2_c4_req", 32'(bus.mem_req_o), 32'h1);
    chk("t2_c4_addr", bus.mem_addr_o, 32'h200);
    chk("t2_c4_gnt", {30'h0, bus.a_gnt_o, bus.b_gnt_o}, 32'h3);
    cyc();
    idle_cores(); bus.mem_rdata_i = 32'h12345678;
    #3 chk("t2_c5_rdata_masked", bus.rdata_o, 32'h0);
    cyc();
    bus.mem_rvalid_i = 1'b1;
    #3;
    chk("t2_c6_rvalid", {30'h0, bus.a_rvalid_o, bus.b_rvalid_o}, 32'h3);
    chk("t2_c6_rdata", bus.rdata_o, 32'h12345678);

    // 5: back-to-back read whose wdata differs between cores
    cyc();
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    drv_a(1'b1, 1'b0, 4'hF, 32'h40, 32'hAA);
    drv_b(1'b1, 1'b0, 4'hF, 32'h40, 32'h55);
    cyc();
    #3;
    chk("t5_req", 32'(bus.mem_req_o), 32'h1);
    chk("t5_addr", bus.mem_addr_o, 32'h40);
    chk("t5_wdata_from_a", bus.mem_wdata_o, 32'hAA);
    chk("t5_no_fault", 32'(fault), 32'h0);
    cyc();
    idle_cores(); bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hCAFE0001;
    #3 chk("t5_rdata", bus.rdata_o, 32'hCAFE0001);
    cyc();
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;

    // 3: write data mismatch
    drv_a(1'b1, 1'b1, 4'hF, 32'h300, 32'h1);
    drv_b(1'b1, 1'b1, 4'hF, 32'h300, 32'h2);
    base = req_cycles;
    cyc();
    #3;
    chk("t3_fault", 32'(fault), 32'h1);
    chk("t3_cause", 32'(fault_cause), 32'h1);
    chk("t3_cnt", 32'(fault_cnt), 32'h1);
    chk("t3_no_gnt", {30'h0, bus.a_gnt_o, bus.b_gnt_o}, 32'h0);
    cyc();
    idle_cores(); clear = 1'b1;
    #3 chk("t3_fault_held", 32'(fault), 32'h1);
    cyc();
    clear = 1'b0;
    #3;
    chk("t3_cleared", {29'h0, fault, fault_cause}, 32'h0);
    chk("t3_cnt_kept", 32'(fault_cnt), 32'h1);
    chk("t3_no_issue", 32'(req_cycles - base), 32'h0);

    // 4: only B requests -> timeout
    drv_b(1'b1, 1'b1, 4'hF, 32'h500, 32'h77);
    base = req_cycles;
    for (int i = 1; i <= SKEW_MAX; i++) begin
      cyc();
      #3 chk($sformatf("t4_c%0d_no_fault", i), 32'(fault), 32'h0);
    end
    cyc();
    #3;
    chk("t4_fault", 32'(fault), 32'h1);
    chk("t4_cause", 32'(fault_cause), 32'h2);
    chk("t4_cnt", 32'(fault_cnt), 32'h2);
    chk("t4_no_issue", 32'(req_cycles - base), 32'h0);
    cyc();
    idle_cores(); clear = 1'b1;
    cyc();
    clear = 1'b0;

    // 4b: peer arrives exactly SKEW_MAX cycles late -> still a timeout
    drv_a(1'b1, 1'b0, 4'hF, 32'h600, 32'h0);
    for (int i = 1; i <= SKEW_MAX; i++) begin
      cyc();
      if (i == SKEW_MAX) drv_b(1'b1, 1'b0, 4'hF, 32'h600, 32'h0);
    end
    cyc();
    #3;
    chk("t4b_cause", 32'(fault_cause), 32'h2);
    chk("t4b_cnt", 32'(fault_cnt), 32'h3);
    cyc();
    idle_cores(); clear = 1'b1;
    cyc();
    clear = 1'b0;

    // first core drops its request; captured fields still win
    drv_a(1'b1, 1'b1, 4'h3, 32'h700, 32'h11);
    cyc();
    drv_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cyc();
    drv_b(1'b1, 1'b1, 4'h3, 32'h700, 32'h11);
    cyc();
    idle_cores();
    #3;
    chk("drop_addr", bus.mem_addr_o, 32'h700);
    chk("drop_be", 32'(bus.mem_be_o), 32'h3);
    chk("drop_wdata", bus.mem_wdata_o, 32'h11);
    cyc();
    bus.mem_rvalid_i = 1'b1;
    cyc();
    bus.mem_rvalid_i = 1'b0;

    // 6a: asynchronous reset while waiting for the response
    drv_a(1'b1, 1'b0, 4'hF, 32'h800, 32'h0);
    drv_b(1'b1, 1'b0, 4'hF, 32'h800, 32'h0);
    cyc();
    cyc();
    idle_cores();
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h5A5A5A5A;
    #1 chk("t6_pre_rvalid", 32'(bus.a_rvalid_o), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rvalid", {30'h0, bus.a_rvalid_o, bus.b_rvalid_o}, 32'h0);
    chk("t6_rst_rdata", bus.rdata_o, 32'h0);
    chk("t6_rst_req", 32'(bus.mem_req_o), 32'h0);
    chk("t6_rst_cnt", 32'(fault_cnt), 32'h0);
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    cyc();
    drv_a(1'b1, 1'b0, 4'hF, 32'h804, 32'h0);
    drv_b(1'b1, 1'b0, 4'hF, 32'h804, 32'h0);
    cyc();
    #3;
    chk("t6_post_req", 32'(bus.mem_req_o), 32'h1);
    chk("t6_post_addr", bus.mem_addr_o, 32'h804);
    cyc();
    idle_cores(); bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0BADF00D;
    #3 chk("t6_post_rdata", bus.rdata_o, 32'h0BADF00D);
    cyc();
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;

    // 6b: counter saturation, 2^CNT_W + 2 faults in total
    for (int i = 0; i < 254; i++) fault_once();
    #3 chk("t6_cnt_254", 32'(fault_cnt), 32'd254);
    fault_once();
    #3 chk("t6_cnt_255", 32'(fault_cnt), 32'd255);
    for (int i = 0; i < 3; i++) fault_once();
    #3 chk("t6_cnt_sat", 32'(fault_cnt), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
